// File: rtl/mda_motor_pwm_gen.sv
// Per-motor PWM/direction generator for BTS7960 half-bridges with boundary-aligned duty updates and reversal dead time.
// Optional write-inactivity watchdog enabled by defining MDA_MOTOR_WATCHDOG_EN.

module mda_motor_pwm_ch #(
  parameter int CW           = 12,
  parameter int DEAD_PERIODS = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [CW-1:0] cnt,
  input  logic          bnd,
  input  logic          wr,
  input  logic [13:0]   cmd,
  input  logic          clr,
  output logic [3:0]    gpio,
  output logic          dead
);
  localparam int DW = $clog2(DEAD_PERIODS + 1);
  localparam int XW = (CW > 12) ? CW : 12;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RUN_FWD = 2'd1;
  localparam logic [1:0] RUN_REV = 2'd2;
  localparam logic [1:0] DEAD    = 2'd3;

  typedef struct packed {
    logic        dir;
    logic        en;
    logic [11:0] duty;
  } cmd_t;

  cmd_t          shadow, act;
  logic [1:0]    state;
  logic [DW-1:0] dcnt;
  logic [XW-1:0] cnt_x, duty_x;
  logic          raw;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  shadow <= '0;
    else if (wr)   shadow <= cmd_t'(cmd);
    else if (clr)  shadow <= '0;
  end

  // The FSM decides on the value being loaded into act on this same boundary.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      act   <= '0;
      state <= IDLE;
      dcnt  <= '0;
    end else if (bnd) begin
      act <= shadow;
      case (state)
        IDLE: begin
          if (shadow.en) state <= shadow.dir ? RUN_REV : RUN_FWD;
        end
        RUN_FWD: begin
          if (!shadow.en) state <= IDLE;
          else if (shadow.dir && shadow.duty != '0) begin
            state <= DEAD;
            dcnt  <= DW'(DEAD_PERIODS);
          end
        end
        RUN_REV: begin
          if (!shadow.en) state <= IDLE;
          else if (!shadow.dir && shadow.duty != '0) begin
            state <= DEAD;
            dcnt  <= DW'(DEAD_PERIODS);
          end
        end
        default: begin
          if (!shadow.en) state <= IDLE;
          else if (dcnt <= DW'(1)) begin
            state <= shadow.dir ? RUN_REV : RUN_FWD;
            dcnt  <= '0;
          end else dcnt <= dcnt - DW'(1);
        end
      endcase
    end
  end

  assign cnt_x  = XW'(cnt);
  assign duty_x = XW'(act.duty);
  assign raw    = cnt_x < duty_x;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gpio <= '0;
      dead <= 1'b0;
    end else begin
      gpio <= {raw & (state == RUN_FWD || state == RUN_REV),
               raw & (state == RUN_FWD),
               raw & (state == RUN_REV),
               state != IDLE};
      dead <= state == DEAD;
    end
  end
endmodule

module mda_motor_pwm_gen #(
  parameter int NUM_MOTORS   = 8,
  parameter int PERIOD       = 2500,
  parameter int DEAD_PERIODS = 2,
  parameter int WDOG_CYCLES  = 50_000_000
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          wr_en,
  input  logic [$clog2(NUM_MOTORS)-1:0] wr_addr,
  input  logic [15:0]                   wr_data,
  output logic [4*NUM_MOTORS-1:0]       gpio_out,
  output logic [NUM_MOTORS-1:0]         dead_active,
  output logic                          wdog_trip
);
  localparam int AW = $clog2(NUM_MOTORS);
  localparam int CW = $clog2(PERIOD);

  logic [CW-1:0]                cnt;
  logic                         bnd;
  logic                         wd_clr;
  logic [NUM_MOTORS-1:0][3:0]   gpio;
  logic [13:0]                  cmd;
  logic [1:0]                   unused_bits;

  assign bnd         = cnt == CW'(PERIOD - 1);
  assign cmd         = {wr_data[15:14], wr_data[11:0]};
  assign unused_bits = wr_data[13:12];
  assign gpio_out    = gpio;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  cnt <= '0;
    else if (bnd)  cnt <= '0;
    else           cnt <= cnt + CW'(1);
  end

`ifdef MDA_MOTOR_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  logic [WW-1:0] wcnt;

  // Any strobe counts as activity, even to an out-of-range address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wcnt      <= '0;
      wdog_trip <= 1'b0;
    end else if (wr_en) begin
      wcnt      <= '0;
      wdog_trip <= 1'b0;
    end else if (wcnt != WW'(WDOG_CYCLES)) begin
      wcnt <= wcnt + WW'(1);
      if (wcnt == WW'(WDOG_CYCLES - 1)) wdog_trip <= 1'b1;
    end
  end

  assign wd_clr = !wr_en && (wcnt == WW'(WDOG_CYCLES - 1));
`else
  logic [31:0] unused_wdog;
  assign unused_wdog = WDOG_CYCLES;
  assign wdog_trip   = 1'b0;
  assign wd_clr      = 1'b0;
`endif

  for (genvar m = 0; m < NUM_MOTORS; m++) begin : g_ch
    mda_motor_pwm_ch #(
      .CW           (CW),
      .DEAD_PERIODS (DEAD_PERIODS)
    ) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .cnt     (cnt),
      .bnd     (bnd),
      .wr      (wr_en && wr_addr == AW'(m)),
      .cmd     (cmd),
      .clr     (wd_clr),
      .gpio    (gpio[m]),
      .dead    (dead_active[m])
    );
  end
endmodule

// File: tb/tb_mda_motor_pwm_gen.sv
// Directed bench for mda_motor_pwm_gen: 6 motors, PERIOD=100, DEAD_PERIODS=2, WDOG_CYCLES=1000.
module tb_mda_motor_pwm_gen;
  localparam int NM  = 6;
  localparam int PER = 100;
`ifdef MDA_MOTOR_WATCHDOG_EN
  localparam int WD = 1;
`else
  localparam int WD = 0;
`endif

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            wr_en = 1'b0;
  logic [2:0]      wr_addr = '0;
  logic [15:0]     wr_data = '0;
  logic [4*NM-1:0] gpio_out;
  logic [NM-1:0]   dead_active;
  logic            wdog_trip;

  int nchk = 0;
  int nerr = 0;
  int ecnt = 0;

  mda_motor_pwm_gen #(
    .NUM_MOTORS   (NM),
    .PERIOD       (PER),
    .DEAD_PERIODS (2),
    .WDOG_CYCLES  (1000)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .gpio_out    (gpio_out),
    .dead_active (dead_active),
    .wdog_trip   (wdog_trip)
  );

  always #5 clk = ~clk;

  // Independent period position: edges since reset release, modulo PER.
  always @(posedge clk or negedge reset_n)
    if (!reset_n) ecnt <= 0;
    else          ecnt <= ecnt + 1;

  task automatic chk(input string tag, input int obs, input int exp_v);
    nchk++;
    if (obs !== exp_v) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic to_cnt(input int v);
    for (int i = 0; i < PER + 2 && (ecnt % PER) != v; i++) tick();
  endtask

  task automatic wr(input int a, input int d);
    wr_en   = 1'b1;
    wr_addr = 3'(a);
    wr_data = 16'(d);
    tick();
    wr_en   = 1'b0;
  endtask

  function automatic logic [3:0] mg(input int m);
    return gpio_out[4*m +: 4];
  endfunction

  task automatic meas(input int m, input int n, output int f, output int r, output int p,
                      output int e, output int b, output int d, output int fend, output int rbeg);
    logic [3:0] g;
    f = 0; r = 0; p = 0; e = 0; b = 0; d = 0; fend = 0; rbeg = -1;
    for (int j = 0; j < n; j++) begin
      tick();
      g = mg(m);
      if (g[2]) begin f++; fend = j + 1; end
      if (g[1]) begin r++; if (rbeg < 0) rbeg = j; end
      p += int'(g[3]);
      e += int'(g[0]);
      b += int'(g[2] & g[1]);
      d += int'(dead_active[m]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int f, r, p, e, b, d, fend, rbeg, nz;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gpio", int'(gpio_out), 0);
    chk("rst_dead", int'(dead_active), 0);
    chk("rst_trip", int'(wdog_trip), 0);
    #3 reset_n = 1'b1;
    tick();
    chk("post_rst_gpio", int'(gpio_out), 0);

    // Duty on motor 3
    to_cnt(10);
    wr(3, 16'h4019);
    to_cnt(0);
    chk("m3_before_latency", int'(mg(3)), 0);
    meas(3, PER, f, r, p, e, b, d, fend, rbeg);
    chk("d25_fwd", f, 25);
    chk("d25_fend", fend, 25);
    chk("d25_pwm", p, 25);
    chk("d25_rev", r, 0);
    chk("d25_en", e, 100);
    wr(3, 16'h4000);
    to_cnt(0);
    meas(3, PER, f, r, p, e, b, d, fend, rbeg);
    chk("d0_fwd", f, 0);
    chk("d0_en", e, 100);
    wr(3, 16'h4FFF);
    to_cnt(0);
    meas(3, PER, f, r, p, e, b, d, fend, rbeg);
    chk("dsat_fwd", f, 100);
    chk("dsat_rev", r, 0);
    wr(3, 16'h0000);
    to_cnt(0);
    tick();
    chk("m3_off", int'(mg(3)), 0);

    // Reversal on motor 0
    wr(0, 16'h4032);
    to_cnt(0);
    meas(0, PER, f, r, p, e, b, d, fend, rbeg);
    chk("rv_pre_fwd", f, 50);
    chk("rv_pre_fend", fend, 50);
    wr(0, 16'hC000);
    to_cnt(0);
    meas(0, PER, f, r, p, e, b, d, fend, rbeg);
    chk("rv_duty0_dead", d, 0);
    chk("rv_duty0_rev", r, 0);
    chk("rv_duty0_en", e, 100);
    wr(0, 16'hC032);
    to_cnt(0);
    meas(0, 3 * PER, f, r, p, e, b, d, fend, rbeg);
    chk("rv_dead_cycles", d, 200);
    chk("rv_fwd", f, 0);
    chk("rv_rev", r, 50);
    chk("rv_rev_start", rbeg, 200);
    chk("rv_both", b, 0);
    chk("rv_en", e, 300);
    wr(0, 16'h0000);

    // Shadow timing on motor 1
    to_cnt(20);
    wr(1, 16'h400A);
    to_cnt(40);
    wr(1, 16'h4014);
    to_cnt(0);
    meas(1, PER, f, r, p, e, b, d, fend, rbeg);
    chk("sh_last_wins", f, 20);
    chk("sh_last_fend", fend, 20);
    to_cnt(99);
    wr(1, 16'h4028);
    meas(1, PER, f, r, p, e, b, d, fend, rbeg);
    chk("sh_bnd_not_taken", f, 20);
    meas(1, PER, f, r, p, e, b, d, fend, rbeg);
    chk("sh_bnd_next", f, 40);

    // Reset mid-operation
    to_cnt(10);
    chk("mid_fwd_hi", int'(mg(1)), 4'b1101);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_gpio", int'(gpio_out), 0);
    chk("mid_rst_dead", int'(dead_active), 0);
    @(posedge clk);
    @(posedge clk);
    #3 reset_n = 1'b1;
    nz = 0;
    for (int i = 0; i < 250; i++) begin
      tick();
      if (gpio_out != '0 || dead_active != '0) nz++;
    end
    chk("post_rst_quiet", nz, 0);

    // Watchdog
    to_cnt(50);
    wr(2, 16'h4032);
    for (int i = 1; i <= 999; i++) begin
      tick();
      if (i == 150) chk("wd_m2_running", int'(mg(2) & 4'b0001), 1);
    end
    chk("wd_trip_early", int'(wdog_trip), 0);
    tick();
    chk("wd_trip", int'(wdog_trip), WD);
    tick();
    to_cnt(0);
    tick();
    chk("wd_m2_en", int'(mg(2) & 4'b0001), 1 - WD);
    wr(2, 16'h0000);
    chk("wd_trip_clr", int'(wdog_trip), 0);
    to_cnt(0);
    tick();
    chk("wd_all_idle", int'(gpio_out), 0);

    // Out-of-range addresses: no effect, but still count as activity
    nz = 0;
    for (int k = 0; k < 3; k++) begin
      wr((k == 1) ? 6 : 7, 16'h4FFF);
      for (int i = 0; i < 499; i++) begin
        tick();
        if (gpio_out != '0 || dead_active != '0) nz++;
      end
    end
    chk("addr_ignored", nz, 0);
    chk("addr_no_trip", int'(wdog_trip), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/mda_motor_pwm_gen.md
# mda_motor_pwm_gen

Per-motor PWM and direction generator for the BTS7960 half-bridge drivers. It sits directly upstream of the global-disable stage and drives the `{hb8..hb1}` motor buses: 8 motors, 4 bits each. Software duty/direction words are written over a simple register-write port. Duty changes are applied glitch-free at PWM period boundaries, and a dead interval is inserted on every direction reversal.

## Interface
Parameters:
- `NUM_MOTORS`, default 8: number of motor channels.
- `PERIOD`, default 2500: PWM period in clk cycles (20 kHz at 50 MHz).
- `DEAD_PERIODS`, default 2: full PWM periods with both half-bridges low on reversal; must be ≥1.
- `WDOG_CYCLES`, default 50_000_000: write-inactivity timeout (1 s).

Ports:
- `clk` input, 1 bit: system clock (CLOCK_50 domain).
- `reset_n` input, 1 bit: asynchronous, active-low reset.
- `wr_en` input, 1 bit: write strobe, one cycle per write.
- `wr_addr` input, `$clog2(NUM_MOTORS)` bits: motor index; values ≥ `NUM_MOTORS` are ignored.
- `wr_data` input, 16 bits: the command word.
  - [15] is dir (0 = forward, 1 = reverse).
  - [14] is enable.
  - [11:0] is duty magnitude.
  - [13:12] are ignored.
- `gpio_out` output, `4*NUM_MOTORS` bits: motor m occupies [4m+3:4m] as {pwm, forward, reverse, enable}. Motor 0 is in the LSBs.
- `dead_active` output, `NUM_MOTORS` bits: motor m is in the DEAD state.
- `wdog_trip` output, 1 bit: the watchdog has expired and no write has occurred since.

## Operation
- **Shared period counter** `cnt` counts 0..`PERIOD`-1 and then wraps. The "boundary" is the edge on which `cnt` goes from `PERIOD`-1 to 0.
- **Shadow register per motor**
  - Written on `wr_en`; the last write before a boundary wins.
  - On each boundary, every shadow is copied into that motor's active register.
  - A write on the boundary cycle itself is not captured by that boundary; it applies at the next one.
- **PWM compare:** raw = (`cnt` < active duty).
  - Duty 0 gives a raw signal that is never high.
  - Duty ≥ `PERIOD` saturates to 100%.
  - The comparison is unsigned; duty is zero-extended to the counter width.
- **Per-motor FSM** (IDLE, RUN_FWD, RUN_REV, DEAD). Transitions are evaluated only at boundaries, using the newly loaded active value.
  - IDLE: if enable=0, stay. If enable=1, go to RUN_FWD or RUN_REV per dir, with no dead time.
  - RUN_FWD: if enable=0, go to IDLE. If dir=1 with duty≠0, go to DEAD (dead count = `DEAD_PERIODS`). Otherwise stay.
  - RUN_REV: mirror of RUN_FWD (dir=0 with duty≠0 triggers DEAD).
  - Duty 0 with the opposite dir does not reverse; the motor stays in its current RUN state with 0% duty.
  - DEAD: decrement the count at each boundary.
    - If enable=0 at any boundary, go to IDLE.
    - When the count reaches 0, go to RUN per the current active dir.
- **Outputs per motor** (registered):
  - enable = state ≠ IDLE.
  - pwm = raw in RUN states, 0 otherwise.
  - forward = raw in RUN_FWD only.
  - reverse = raw in RUN_REV only.
  - forward and reverse are never both 1.
- **Watchdog:** see Configuration.

## Timing
- **Reset values** (all asynchronous):
  - `gpio_out` = 0, `dead_active` = 0, `wdog_trip` = 0.
  - `cnt` = 0.
  - All shadow and active registers = 0; all FSMs = IDLE.
- **Output latency:** outputs are registered one cycle behind (`cnt`, active, state).
  - A boundary at edge k (`cnt`=0 after k) first shows the new duty and state on `gpio_out` after edge k+1.
- **Write-to-output latency:**
  - Minimum 2 cycles (write at `cnt`=`PERIOD`-2).
  - Maximum `PERIOD`+1 cycles.
- **Reversal:** the old direction ends at a boundary. Both half-bridges stay low for exactly `DEAD_PERIODS`×`PERIOD` cycles, then the new direction starts.
- **Reset mid-operation:** all outputs go low immediately; no dead time is owed after reset release.

## Configuration
- **Macro `MDA_MOTOR_WATCHDOG_EN` defined:**
  - A counter clears on every `wr_en`, including writes with an ignored address.
  - When the counter reaches `WDOG_CYCLES`, all shadow registers are cleared (enable=0) and `wdog_trip` is set. Motors go to IDLE at the next boundary.
  - A write and an expiry in the same cycle: the write wins (no trip).
  - `wdog_trip` clears on the next `wr_en`.
- **Not defined:** no watchdog logic; `wdog_trip` is tied to 0; the shadow registers hold their values indefinitely.

## Test plan
Bench parameters: `PERIOD`=100, `DEAD_PERIODS`=2, `WDOG_CYCLES`=1000.
- **Reset:** assert `reset_n`=0 mid-PWM → `gpio_out`=0 in the same cycle. Release → all motors IDLE and `gpio_out` stays 0.
- **Duty:** write motor 3 with 0x4019 (enable, fwd, duty 25) → enable=1, forward high 25 of every 100 cycles, reverse=0, starting at boundary+1. Duty 0x4000 → forward never high, enable=1. Duty 0x4FFF → forward constantly 1.
- **Reversal:** motor 0 running 0x4032 (fwd, duty 50), then write 0xC032 → forward low from the boundary; `dead_active`[0]=1 for 200 cycles; then reverse high 50 of every 100 cycles. forward and reverse are never both high.
- **Shadow timing:** write 0x400A then 0x4014 within one period → only duty 20 is applied. A write on the boundary cycle is applied one period later.
- **Watchdog** (macro on): one write 0x4032, then idle 1000 cycles → `wdog_trip`=1; motor goes IDLE at the next boundary; the next write clears `wdog_trip`. With the macro off, the motor runs indefinitely and `wdog_trip`=0.
- **Address range:** `wr_addr`=7 on a 6-motor build → no output change, no watchdog trip.
